noc_vc_input_buffer: RTL and testbench

Per-virtual-channel input buffer for the router input port, generalising the fixed input FIFO. It splits incoming flits by VC and buffers each VC independently. Depth and almost-full threshold are parameters. Each VC reports live occupancy, and the block raises a sticky flow-control error flag. An optional zero-latency bypass can be compiled in. It sits between the link receiver and the router's route/arbitration stage.

---
 rtl/noc_vc_input_buffer_pkg.sv | 21 ++
 rtl/noc_vc_input_buffer_if.sv | 13 +
 rtl/noc_vc_input_buffer_fifo_core.sv | 80 ++++++++
 rtl/noc_vc_input_buffer.sv | 93 +++++++++
 tb/tb_noc_vc_input_buffer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_vc_input_buffer_pkg.sv
// Router configuration package for the per-VC input buffer slice.
// Optional feature macro used by the top: NOC_INPUT_BUFFER_BYPASS_EN.
package noc_config_pkg;

    localparam int unsigned FLIT_W = 16;

    typedef logic [FLIT_W-1:0] noc_flit_t;

    typedef struct packed {
        int unsigned virtual_channels;
        int unsigned input_fifo_depth;
    } noc_config;

    localparam noc_config NOC_DEFAULT_CONFIG = '{virtual_channels: 2, input_fifo_depth: 4};

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned noc_fifo_count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_vc_input_buffer_if.sv
// Flit handshake bundle: one valid/ready pair per lane, one shared flit.
interface noc_flit_if
    import noc_config_pkg::*;
#(
    parameter int unsigned LANES = 1
);
    logic [LANES-1:0] valid;
    logic [LANES-1:0] ready;
    noc_flit_t        flit;

    modport master (output valid, output flit, input ready);
    modport slave  (input valid, input flit, output ready);
endinterface

// File: rtl/noc_vc_input_buffer_fifo_core.sv
// Single-VC circular buffer with occupancy count and registered status flags.
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1.
module noc_vc_fifo_core
    import noc_config_pkg::*;
#(
    parameter  int unsigned DEPTH     = 4,
    parameter  int unsigned THRESHOLD = 2,
    localparam int unsigned COUNT_W   = noc_fifo_count_width(DEPTH),
    localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  noc_flit_t          data_i,
    output noc_flit_t          data_o,
    output logic [COUNT_W-1:0] count_o,
    output logic               empty_o,
    output logic               almost_full_o,
    output logic               full_o
);

    noc_flit_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               empty_q, almost_full_q, full_q;
    logic               push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // A full buffer never takes a push, even when it pops in the same cycle.
    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    // Next pointers and occupancy from this cycle's push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push_ok && !pop_ok)      count_d = count_q + COUNT_W'(1);
        else if (!push_ok && pop_ok) count_d = count_q - COUNT_W'(1);
    end

    // Control state; flags are derived from the next count so they stay registered.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            almost_full_q <= 1'b0;
            full_q        <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            empty_q       <= (count_d == '0);
            almost_full_q <= (count_d >= COUNT_W'(THRESHOLD));
            full_q        <= (count_d == COUNT_W'(DEPTH));
        end
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok && !clear_i && !rst) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o        = mem_q[rd_ptr_q];
    assign count_o       = count_q;
    assign empty_o       = empty_q;
    assign almost_full_o = almost_full_q;
    assign full_o        = full_q;

endmodule

// File: rtl/noc_vc_input_buffer.sv
// Per-VC input buffer: demuxes the shared input by VC into independent FIFOs,
// generates state-only ready, and tracks a sticky flow-control error.
// Optional zero-latency bypass: define NOC_INPUT_BUFFER_BYPASS_EN.
module noc_vc_input_buffer
    import noc_config_pkg::*;
#(
    parameter  noc_config   CONFIG    = NOC_DEFAULT_CONFIG,
    parameter  int unsigned DEPTH     = CONFIG.input_fifo_depth,
    parameter  int unsigned THRESHOLD = DEPTH - 2,
    localparam int unsigned CHANNELS  = CONFIG.virtual_channels,
    localparam int unsigned COUNT_W   = noc_fifo_count_width(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_clear,
    output logic [CHANNELS-1:0]              o_empty,
    output logic [CHANNELS-1:0]              o_almost_full,
    output logic [CHANNELS-1:0]              o_full,
    output logic [CHANNELS-1:0][COUNT_W-1:0] o_count,
    output logic                             o_error,
    noc_flit_if.slave                        flit_in_if,
    noc_flit_if.master                       flit_out_if [CHANNELS]
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("noc_vc_input_buffer: DEPTH must be at least 2");
    end
    if (THRESHOLD < 1 || THRESHOLD > DEPTH - 1) begin : g_bad_threshold
        $error("noc_vc_input_buffer: THRESHOLD must lie in 1..DEPTH-1");
    end

    logic [CHANNELS-1:0] in_valid;
    logic [CHANNELS-1:0] in_ready;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic                error_q, error_d;

    assign in_valid         = flit_in_if.valid;
    assign in_ready         = ~o_full & {CHANNELS{~i_clear}};
    assign flit_in_if.ready = in_ready;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_vc
        noc_flit_t head;
        logic      bypass;

`ifdef NOC_INPUT_BUFFER_BYPASS_EN
        // An empty VC with a ready consumer forwards the input flit without storing it.
        assign bypass               = o_empty[g] && flit_out_if[g].ready && in_valid[g] && in_ready[g];
        assign flit_out_if[g].valid = !o_empty[g] || (in_valid[g] && in_ready[g]);
        assign flit_out_if[g].flit  = o_empty[g] ? flit_in_if.flit : head;
`else
        assign bypass               = 1'b0;
        assign flit_out_if[g].valid = !o_empty[g];
        assign flit_out_if[g].flit  = head;
`endif

        assign push[g] = in_valid[g] && in_ready[g] && !bypass;
        assign pop[g]  = !o_empty[g] && flit_out_if[g].ready;

        noc_vc_fifo_core #(
            .DEPTH     (DEPTH),
            .THRESHOLD (THRESHOLD)
        ) u_core (
            .clk           (clk),
            .rst           (rst),
            .clear_i       (i_clear),
            .push_i        (push[g]),
            .pop_i         (pop[g]),
            .data_i        (flit_in_if.flit),
            .data_o        (head),
            .count_o       (o_count[g]),
            .empty_o       (o_empty[g]),
            .almost_full_o (o_almost_full[g]),
            .full_o        (o_full[g])
        );
    end

    // Violations: offering to a full VC, or more than one VC valid at once.
    always_comb begin
        error_d = error_q;
        if (|(in_valid & o_full)) error_d = 1'b1;
        if ((in_valid & (in_valid - CHANNELS'(1))) != '0) error_d = 1'b1;
    end

    // Sticky error, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (rst || i_clear) error_q <= 1'b0;
        else                error_q <= error_d;
    end

    assign o_error = error_q;

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Scoreboard bench for noc_vc_input_buffer: DUT A uses the default config
// (2 VCs, DEPTH 4, THRESHOLD 2); DUT B uses DEPTH 3 (THRESHOLD 1) for
// non-power-of-two pointer wrap. Default build (NOC_INPUT_BUFFER_BYPASS_EN undefined).
module tb_noc_vc_input_buffer;
    import noc_config_pkg::*;

    logic       clk;
    logic       rst;
    logic       clear;
    logic [1:0] in_valid  [2];
    noc_flit_t  in_flit   [2];
    logic [1:0] out_ready [2];
    logic [1:0] in_ready  [2];
    logic [1:0] ov        [2];
    noc_flit_t  ofl       [2][2];
    logic [1:0] emp [2];
    logic [1:0] af  [2];
    logic [1:0] fu  [2];
    logic [1:0][2:0] cnt_a;
    logic [1:0][1:0] cnt_b;
    logic       err_o [2];

    int        DEP [2];
    int        TH  [2];
    int        ref_cnt [2][2];
    logic      ref_err [2];
    noc_flit_t exp_q [2][2][$];
    int        total;
    int        bad;
    logic      mon_en;

    noc_flit_if #(.LANES(2)) in_a ();
    noc_flit_if #(.LANES(2)) in_b ();
    noc_flit_if              out_a [2] ();
    noc_flit_if              out_b [2] ();

    assign in_a.valid  = in_valid[0];
    assign in_a.flit   = in_flit[0];
    assign in_b.valid  = in_valid[1];
    assign in_b.flit   = in_flit[1];
    assign in_ready[0] = in_a.ready;
    assign in_ready[1] = in_b.ready;

    for (genvar v = 0; v < 2; v++) begin : g_wire
        assign out_a[v].ready = out_ready[0][v];
        assign out_b[v].ready = out_ready[1][v];
        assign ov[0][v]       = out_a[v].valid;
        assign ov[1][v]       = out_b[v].valid;
        assign ofl[0][v]      = out_a[v].flit;
        assign ofl[1][v]      = out_b[v].flit;
    end

    noc_vc_input_buffer u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (clear),
        .o_empty       (emp[0]),
        .o_almost_full (af[0]),
        .o_full        (fu[0]),
        .o_count       (cnt_a),
        .o_error       (err_o[0]),
        .flit_in_if    (in_a),
        .flit_out_if   (out_a)
    );

    noc_vc_input_buffer #(.DEPTH(3)) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (clear),
        .o_empty       (emp[1]),
        .o_almost_full (af[1]),
        .o_full        (fu[1]),
        .o_count       (cnt_b),
        .o_error       (err_o[1]),
        .flit_in_if    (in_b),
        .flit_out_if   (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare status against the model and consume the scoreboard on handshakes.
    always @(negedge clk) begin
        int        c;
        noc_flit_t e;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("error[%0d]", d), int'(err_o[d]), int'(ref_err[d]));
                for (int v = 0; v < 2; v++) begin
                    c = (d == 0) ? int'(cnt_a[v]) : int'(cnt_b[v]);
                    check($sformatf("count[%0d][%0d]", d, v), c, ref_cnt[d][v]);
                    check($sformatf("empty[%0d][%0d]", d, v), int'(emp[d][v]), int'(ref_cnt[d][v] == 0));
                    check($sformatf("afull[%0d][%0d]", d, v), int'(af[d][v]), int'(ref_cnt[d][v] >= TH[d]));
                    check($sformatf("full[%0d][%0d]", d, v), int'(fu[d][v]), int'(ref_cnt[d][v] == DEP[d]));
                    check($sformatf("out_valid[%0d][%0d]", d, v), int'(ov[d][v]), int'(ref_cnt[d][v] > 0));
                    check($sformatf("in_ready[%0d][%0d]", d, v), int'(in_ready[d][v]),
                          int'(ref_cnt[d][v] < DEP[d] && !clear));
                    if (ov[d][v] && out_ready[d][v]) begin
                        if (exp_q[d][v].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL underflow[%0d][%0d]: got output flit %0h, expected none", d, v, ofl[d][v]);
                        end else begin
                            e = exp_q[d][v].pop_front();
                            check($sformatf("flit[%0d][%0d]", d, v), int'(ofl[d][v]), int'(e));
                        end
                    end
                end
            end
        end
    end

    // One cycle of stimulus; predicts acceptance from the spec rules and updates the model at the edge.
    task automatic step(input logic [1:0] v0, input logic [1:0] v1,
                        input logic [1:0] r0, input logic [1:0] r1,
                        input logic clr, input logic rs);
        logic [1:0] vv [2];
        logic [1:0] rr [2];
        int         nc [2][2];
        logic       ne [2];
        vv[0] = v0;
        vv[1] = v1;
        rr[0] = (clr || rs) ? 2'b00 : r0;
        rr[1] = (clr || rs) ? 2'b00 : r1;
        clear = clr;
        rst   = rs;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = vv[d];
            out_ready[d] = rr[d];
            in_flit[d]   = noc_flit_t'($urandom);
            ne[d] = ref_err[d] | (vv[d] == 2'b11);
            for (int v = 0; v < 2; v++) begin
                nc[d][v] = ref_cnt[d][v];
                if (vv[d][v] && ref_cnt[d][v] == DEP[d]) ne[d] = 1'b1;
                if (vv[d][v] && ref_cnt[d][v] < DEP[d] && !clr && !rs) begin
                    exp_q[d][v].push_back(in_flit[d]);
                    nc[d][v]++;
                end
                if (rr[d][v] && ref_cnt[d][v] > 0) nc[d][v]--;
                if (clr || rs) nc[d][v] = 0;
            end
            if (clr || rs) ne[d] = 1'b0;
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            ref_err[d] = ne[d];
            for (int v = 0; v < 2; v++) begin
                ref_cnt[d][v] = nc[d][v];
                if (clr || rs) exp_q[d][v].delete();
            end
        end
        #2;
    endtask

    function automatic logic [1:0] legal_valid(input int d);
        int         v;
        logic [1:0] r;
        v = $urandom_range(0, 2);
        r = '0;
        if (v < 2 && ref_cnt[d][v] < DEP[d]) r[v] = 1'b1;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        DEP[0] = 4; DEP[1] = 3;
        TH[0]  = 2; TH[1]  = 1;
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        clear  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = '0;
            out_ready[d] = '0;
            in_flit[d]   = '0;
            ref_err[d]   = 1'b0;
            for (int v = 0; v < 2; v++) ref_cnt[d][v] = 0;
        end
        @(posedge clk);
        #2;
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        mon_en = 1'b1;

        // Fill VC0 with outputs stalled; DUT B overflows its 3 entries on the 4th push.
        repeat (4) step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        // Push and pop together on a full VC, then a plain push.
        step(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0);
        step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);

        // Streaming on VC1 with the consumer always ready.
        repeat (10) step(2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0);
        repeat (2) step(2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b0);

        // Legal random traffic: one-hot valid to a non-full VC, random back-pressure.
        for (int n = 0; n < 400; n++)
            step(legal_valid(0), legal_valid(1), 2'($urandom), 2'($urandom), 1'b0, 1'b0);

        // Error cases: overfill, multi-valid, then flush.
        repeat (4) step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
        repeat (2) step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        step(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);

        // Reset with entries held, then a push on the following cycle.
        repeat (3) step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
        step(2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

        // Unconstrained traffic with occasional flush and reset.
        for (int n = 0; n < 200; n++)
            step(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                 ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0));

        // Drain everything.
        repeat (12) step(2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++)
            for (int v = 0; v < 2; v++)
                check($sformatf("drained[%0d][%0d]", d, v), exp_q[d][v].size(), 0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
